ps2_key_decoder: RTL and testbench

//  Consumes raw PS/2 set-2 scan-code bytes from the keyboard receiver and turns

---
 rtl/ps2_pkg.sv | 73 +++++++
 rtl/key_event_fifo.sv | 58 +++++
 rtl/ps2_key_decoder.sv | 175 +++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and event record for the PS/2 key decoder.
package ps2_pkg;

  // Prefix bytes that start multi-byte scan-code sequences
  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_E1 = 8'hE1;

  // Controller replies and error bytes that never represent a key
  localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_ERR_LO  = 8'h00;
  localparam logic [7:0] PS2_ERR_HI  = 8'hFF;

  // Modifier base codes; ctrl/alt share a code, E0 selects the right-hand key
  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_ALT    = 8'h11;

  // Bytes following E1 that belong to the Pause sequence
  localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_PAUSE_SKIP
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  // True for bytes the keyboard sends that are not key codes
  function automatic logic is_reply(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
  endfunction

  // Fake shifts the keyboard wraps around E0 keys; they carry no information
  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == KEY_LSHIFT) || (b == KEY_RSHIFT);
  endfunction

  // Modifier vector layout: {ralt,lalt,rctrl,lctrl,rshift,lshift}
  function automatic logic [5:0] apply_mods(input logic [5:0] cur, input key_event_t ev);
    logic [5:0] res;
    res = cur;
    if (!ev.ext) begin
      case (ev.code)
        KEY_LSHIFT: res[0] = !ev.rel;
        KEY_RSHIFT: res[1] = !ev.rel;
        KEY_CTRL:   res[2] = !ev.rel;
        KEY_ALT:    res[4] = !ev.rel;
        default:    res = cur;
      endcase
    end else begin
      case (ev.code)
        KEY_CTRL: res[3] = !ev.rel;
        KEY_ALT:  res[5] = !ev.rel;
        default:  res = cur;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through FIFO of decoded key events. A push while full is
// accepted only when a pop happens in the same cycle.
module key_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  key_event_t wr_data,
  input  logic       pop,
  output key_event_t rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  key_event_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: strips E0/F0/E1 prefixes, drops controller
// replies, tracks modifier keys and queues key events for the consumer.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_rel,
  output logic [5:0] mods,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  dec_state_t  state;
  dec_state_t  state_next;
  logic [2:0]  skip_cnt;
  logic [2:0]  skip_next;
  logic [TW-1:0] to_cnt;
  logic        timeout_hit;
  logic        commit;
  key_event_t  commit_ev;
  key_event_t  head;
  key_event_t  last_ev;
  key_event_t  shown;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  assign ev_valid    = !fifo_empty;
  assign pop         = ev_ready && ev_valid;
  assign timeout_hit = (state != ST_IDLE) && (to_cnt == TO_LAST);

  // With the FIFO empty the outputs keep showing the most recently popped event
  assign shown    = ev_valid ? head : last_ev;
  assign ev_ext   = shown.ext;
  assign ev_rel   = shown.rel;
  assign ev_code  = shown.code;

  // Decoder state and Pause skip counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  // Prefix decoding: a received byte always wins over an expiring timeout
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    commit     = 1'b0;
    commit_ev  = '0;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == PS2_E0) begin
            state_next = ST_GOT_E0;
          end else if (scan_code == PS2_F0) begin
            state_next = ST_GOT_F0;
          end else if (scan_code == PS2_E1) begin
            state_next = ST_PAUSE_SKIP;
            skip_next  = PAUSE_SKIP_LEN;
          end else if (!is_reply(scan_code)) begin
            commit         = 1'b1;
            commit_ev.code = scan_code;
          end
        end
        ST_GOT_E0: begin
          if (scan_code == PS2_F0) begin
            state_next = ST_GOT_E0F0;
          end else begin
            state_next = ST_IDLE;
            if (!is_fake_shift(scan_code)) begin
              commit         = 1'b1;
              commit_ev.ext  = 1'b1;
              commit_ev.code = scan_code;
            end
          end
        end
        ST_GOT_F0: begin
          state_next     = ST_IDLE;
          commit         = 1'b1;
          commit_ev.rel  = 1'b1;
          commit_ev.code = scan_code;
        end
        ST_GOT_E0F0: begin
          state_next = ST_IDLE;
          if (!is_fake_shift(scan_code)) begin
            commit         = 1'b1;
            commit_ev.ext  = 1'b1;
            commit_ev.rel  = 1'b1;
            commit_ev.code = scan_code;
          end
        end
        ST_PAUSE_SKIP: begin
          if (skip_cnt == 3'd1) begin
            state_next     = ST_IDLE;
            skip_next      = '0;
            commit         = 1'b1;
            commit_ev.code = PS2_E1;
          end else begin
            skip_next = skip_cnt - 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = ST_IDLE;
    end
  end

  // Inter-byte watchdog: counts silent cycles while a prefix is pending
  always_ff @(posedge clk) begin
    if (reset || scan_valid || (state == ST_IDLE) || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Modifier tracking follows every committed event, queued or dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      mods <= '0;
    end else if (commit) begin
      mods <= apply_mods(mods, commit_ev);
    end
  end

  // Sticky overflow when a commit finds the FIFO full with no pop to make room
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (commit && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Remember the event being popped so the outputs hold it once empty
  always_ff @(posedge clk) begin
    if (reset) begin
      last_ev <= '0;
    end else if (pop) begin
      last_ev <= head;
    end
  end

  key_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (commit),
    .wr_data (commit_ev),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed table, multi-cycle corner sequences and
// a randomized byte stream checked against a sequence-level reference model.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       ev_ready;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_rel;
  logic [5:0] mods;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .ev_ready   (ev_ready),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_rel     (ev_rel),
    .mods       (mods),
    .overflow   (overflow)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: pending sequence bytes, event queue, held keys
  logic [7:0] pend [$];
  logic [9:0] mq [$];
  logic [9:0] m_last;
  logic       m_over;
  int         idle;
  logic       lshift, rshift, lctrl, rctrl, lalt, ralt;

  typedef struct {
    logic       sv;
    logic [7:0] code;
    logic       rdy;
    logic       exp_valid;
    logic [9:0] exp_ev;
    logic [5:0] exp_mods;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    m_last = '0;
    m_over = 1'b0;
    idle   = 0;
    {lshift, rshift, lctrl, rctrl, lalt, ralt} = '0;
  endtask

  function automatic logic reply_byte(input logic [7:0] b);
    logic [7:0] replies [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    foreach (replies[i]) if (replies[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Append a byte to the pending sequence and resolve it once it is complete
  task automatic resolve(input logic [7:0] b, output logic c, output logic [9:0] ev);
    c  = 1'b0;
    ev = '0;
    pend.push_back(b);
    if (pend[0] == 8'hE1) begin
      if (pend.size() == 8) begin
        c = 1'b1; ev = {2'b00, 8'hE1}; pend.delete();
      end
    end else if (pend.size() == 1) begin
      if (b != 8'hE0 && b != 8'hF0) begin
        if (!reply_byte(b)) begin c = 1'b1; ev = {2'b00, b}; end
        pend.delete();
      end
    end else if (pend.size() == 2) begin
      if (pend[0] == 8'hF0) begin
        c = 1'b1; ev = {2'b01, b}; pend.delete();
      end else if (b != 8'hF0) begin
        if (b != 8'h12 && b != 8'h59) begin c = 1'b1; ev = {2'b10, b}; end
        pend.delete();
      end
    end else begin
      if (b != 8'h12 && b != 8'h59) begin c = 1'b1; ev = {2'b11, b}; end
      pend.delete();
    end
  endtask

  task automatic model_mods(input logic [9:0] ev);
    logic held;
    held = !ev[8];
    if (ev[9] == 1'b0) begin
      if (ev[7:0] == 8'h12) lshift = held;
      if (ev[7:0] == 8'h59) rshift = held;
      if (ev[7:0] == 8'h14) lctrl  = held;
      if (ev[7:0] == 8'h11) lalt   = held;
    end else begin
      if (ev[7:0] == 8'h14) rctrl  = held;
      if (ev[7:0] == 8'h11) ralt   = held;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it
  task automatic step(input logic sv, input logic [7:0] code, input logic rdy);
    logic       c;
    logic       pop;
    logic [9:0] ev;
    logic [9:0] exp_ev;
    scan_valid = sv;
    scan_code  = code;
    ev_ready   = rdy;
    @(posedge clk);
    c   = 1'b0;
    ev  = '0;
    pop = rdy && (mq.size() > 0);
    if (sv) begin
      idle = 0;
      resolve(code, c, ev);
    end else if (pend.size() > 0) begin
      idle++;
      if (idle >= TMO) begin
        pend.delete();
        idle = 0;
      end
    end
    if (pop) m_last = mq.pop_front();
    if (c) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else m_over = 1'b1;
      model_mods(ev);
    end
    #1;
    exp_ev = (mq.size() > 0) ? mq[0] : m_last;
    chk("model ev_valid", ev_valid, (mq.size() > 0));
    chk("model event", {ev_ext, ev_rel, ev_code}, exp_ev);
    chk("model mods", mods, {ralt, lalt, rctrl, lctrl, rshift, lshift});
    chk("model overflow", overflow, m_over);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
    ev_ready   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1;
    chk("reset ev_valid", ev_valid, 1'b0);
    chk("reset event", {ev_ext, ev_rel, ev_code}, 10'h000);
    chk("reset mods", mods, 6'h00);
    chk("reset overflow", overflow, 1'b0);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 15))
      0:  return 8'hE0;
      1:  return 8'hF0;
      2:  return 8'hE1;
      3:  return 8'h12;
      4:  return 8'h59;
      5:  return 8'h14;
      6:  return 8'h11;
      7:  return 8'hAA;
      8:  return 8'hFA;
      9:  return 8'h00;
      10: return 8'hFF;
      11: return 8'hEE;
      12: return 8'hF0;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [7:0] pause_seq [8];
    logic [7:0] makes [5];

    tbl[0]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 10'h01C, 6'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 10'h01C, 6'h00};
    tbl[2]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 10'h01C, 6'h00};
    tbl[3]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 10'h11C, 6'h00};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 10'h11C, 6'h00};
    tbl[5]  = '{1'b1, 8'hE0, 1'b0, 1'b0, 10'h11C, 6'h00};
    tbl[6]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 10'h11C, 6'h00};
    tbl[7]  = '{1'b1, 8'h75, 1'b0, 1'b1, 10'h375, 6'h00};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 10'h375, 6'h00};
    tbl[9]  = '{1'b1, 8'hE0, 1'b0, 1'b0, 10'h375, 6'h00};
    tbl[10] = '{1'b1, 8'h12, 1'b0, 1'b0, 10'h375, 6'h00};
    tbl[11] = '{1'b1, 8'hE0, 1'b0, 1'b0, 10'h375, 6'h00};
    tbl[12] = '{1'b1, 8'h70, 1'b0, 1'b1, 10'h270, 6'h00};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 10'h270, 6'h00};
    tbl[14] = '{1'b1, 8'hFA, 1'b0, 1'b0, 10'h270, 6'h00};
    tbl[15] = '{1'b1, 8'hAA, 1'b0, 1'b0, 10'h270, 6'h00};
    tbl[16] = '{1'b1, 8'hEE, 1'b0, 1'b0, 10'h270, 6'h00};
    tbl[17] = '{1'b1, 8'h12, 1'b0, 1'b1, 10'h012, 6'h01};
    tbl[18] = '{1'b1, 8'hE0, 1'b1, 1'b0, 10'h012, 6'h01};
    tbl[19] = '{1'b1, 8'h11, 1'b0, 1'b1, 10'h211, 6'h21};
    tbl[20] = '{1'b1, 8'hF0, 1'b1, 1'b0, 10'h211, 6'h21};
    tbl[21] = '{1'b1, 8'h12, 1'b0, 1'b1, 10'h112, 6'h20};
    tbl[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 10'h112, 6'h20};
    tbl[23] = '{1'b1, 8'h29, 1'b1, 1'b1, 10'h029, 6'h20};
    tbl[24] = '{1'b0, 8'h00, 1'b1, 1'b0, 10'h029, 6'h20};

    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    makes     = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};

    do_reset();

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].sv, tbl[i].code, tbl[i].rdy);
      chk("tbl ev_valid", ev_valid, tbl[i].exp_valid);
      chk("tbl event", {ev_ext, ev_rel, ev_code}, tbl[i].exp_ev);
      chk("tbl mods", mods, tbl[i].exp_mods);
    end

    // Reset in the middle of a prefix discards it
    step(1'b1, 8'hE0, 1'b0);
    do_reset();
    step(1'b1, 8'h1C, 1'b0);
    chk("post-reset event", {ev_valid, ev_ext, ev_rel, ev_code}, 11'h41C);
    step(1'b0, 8'h00, 1'b1);

    // Pause: eight bytes, one event on the last
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pause_seq[i], 1'b0);
      if (i < 7) chk("pause no event", ev_valid, 1'b0);
      else       chk("pause event", {ev_valid, ev_ext, ev_rel, ev_code}, 11'h4E1);
    end
    step(1'b0, 8'h00, 1'b1);

    // E0 followed by a full timeout of silence is forgotten
    step(1'b1, 8'hE0, 1'b0);
    repeat (TMO) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    chk("timeout expired", {ev_valid, ev_ext, ev_rel, ev_code}, 11'h41C);
    step(1'b0, 8'h00, 1'b1);

    // One cycle short of the timeout the prefix still applies
    step(1'b1, 8'hE0, 1'b0);
    repeat (TMO - 1) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    chk("timeout edge", {ev_valid, ev_ext, ev_rel, ev_code}, 11'h61C);
    step(1'b0, 8'h00, 1'b1);

    // Fill past capacity, then push and pop together while full
    for (int i = 0; i < 5; i++) begin
      step(1'b1, makes[i], 1'b0);
      if (i == 3) chk("full no overflow", overflow, 1'b0);
    end
    chk("overflow set", overflow, 1'b1);
    chk("full head", {ev_valid, ev_ext, ev_rel, ev_code}, 11'h41C);
    step(1'b1, 8'h2B, 1'b1);
    chk("push+pop full head", {ev_valid, ev_ext, ev_rel, ev_code}, 11'h432);
    step(1'b0, 8'h00, 1'b1);
    chk("drain 1", {ev_valid, ev_ext, ev_rel, ev_code}, 11'h421);
    step(1'b0, 8'h00, 1'b1);
    chk("drain 2", {ev_valid, ev_ext, ev_rel, ev_code}, 11'h423);
    step(1'b0, 8'h00, 1'b1);
    chk("drain 3", {ev_valid, ev_ext, ev_rel, ev_code}, 11'h42B);
    step(1'b0, 8'h00, 1'b1);
    chk("drain empty", {ev_valid, ev_ext, ev_rel, ev_code}, 11'h02B);
    chk("overflow sticky", overflow, 1'b1);

    do_reset();

    // Randomized stream with occasional long gaps around the timeout length
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        repeat ($urandom_range(TMO - 2, TMO + 2)) step(1'b0, 8'h00, 1'($urandom));
      end else begin
        step(r < 60, pick_byte(), ($urandom_range(0, 2) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
